// File: rtl/seq_accumulator.sv
// Block accumulator: sums COUNT unsigned samples per block with per-sample
// wrap or saturate arithmetic, then holds the result until it is consumed.
module seq_accumulator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sum,
  input  logic             out_ready,
  output logic             overflow,
  output logic [7:0]       sample_cnt
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("seq_accumulator: WIDTH must be in 2..32");
  end
  if (COUNT < 1 || COUNT > 255) begin : g_bad_count
    $error("seq_accumulator: COUNT must be in 1..255");
  end

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(COUNT);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sum_q, sum_nxt;
  logic             ovf_q, ovf_nxt;
  logic [7:0]       cnt_q, cnt_nxt;

  logic             accept;
  logic [WIDTH:0]   add_full;
  logic             carry;
  logic [WIDTH-1:0] add_res;

  assign accept   = in_valid && (state == ACCUM);
  // One extra bit captures the carry out of the unsigned add.
  assign add_full = {1'b0, sum_q} + {1'b0, in_data};
  assign carry    = add_full[WIDTH];
  assign add_res  = (mode && carry) ? {WIDTH{1'b1}} : add_full[WIDTH-1:0];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_nxt = state;
    sum_nxt   = sum_q;
    ovf_nxt   = ovf_q;
    cnt_nxt   = cnt_q;

    if (clear) begin
      state_nxt = ACCUM;
      sum_nxt   = '0;
      ovf_nxt   = 1'b0;
      cnt_nxt   = '0;
    end else if (state == HOLD) begin
      if (out_ready) begin
        state_nxt = ACCUM;
        sum_nxt   = '0;
        ovf_nxt   = 1'b0;
        cnt_nxt   = '0;
      end
    end else if (accept) begin
      sum_nxt = add_res;
      ovf_nxt = ovf_q | carry;
      cnt_nxt = cnt_q + 8'd1;
      if (cnt_q + 8'd1 == LAST_CNT) begin
        state_nxt = HOLD;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ACCUM;
      sum_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      sum_q <= sum_nxt;
      ovf_q <= ovf_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  assign in_ready   = (state == ACCUM);
  assign out_valid  = (state == HOLD);
  assign out_sum    = sum_q;
  assign overflow   = ovf_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_seq_accumulator.sv
// Bench for seq_accumulator: a queue-based block model checked every negedge,
// plus directed scenarios with hand-computed literal results.
module tb_seq_accumulator;
  localparam int WIDTH = 8;
  localparam int COUNT = 4;
  localparam longint MAXV = (64'd1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             clear = 1'b0;
  logic             mode = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_sum;
  logic             out_ready = 1'b0;
  logic             overflow;
  logic [7:0]       sample_cnt;

  int total = 0;
  int bad = 0;

  seq_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT)) u_dut (
    .clk(clk), .reset(reset), .clear(clear), .mode(mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_sum(out_sum), .out_ready(out_ready),
    .overflow(overflow), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  // Model: the samples (with their mode) accepted into the current block.
  int q_data[$];
  bit q_mode[$];

  function automatic void model_eval(output longint s, output bit ov);
    s = 0;
    ov = 1'b0;
    foreach (q_data[i]) begin
      longint t;
      t = s + q_data[i];
      if (t > MAXV) begin
        ov = 1'b1;
        t = q_mode[i] ? MAXV : (t % (MAXV + 1));
      end
      s = t;
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_data.delete();
      q_mode.delete();
    end else if (clear) begin
      q_data.delete();
      q_mode.delete();
    end else if (q_data.size() == COUNT) begin
      if (out_ready) begin
        q_data.delete();
        q_mode.delete();
      end
    end else if (in_valid) begin
      q_data.push_back(int'(in_data));
      q_mode.push_back(mode);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    longint s;
    bit ov;
    bit full;
    model_eval(s, ov);
    full = (q_data.size() == COUNT);
    check("in_ready",   32'(in_ready),   32'(!full));
    check("out_valid",  32'(out_valid),  32'(full));
    check("out_sum",    32'(out_sum),    32'(s));
    check("overflow",   32'(overflow),   32'(ov));
    check("sample_cnt", 32'(sample_cnt), 32'(q_data.size()));
  end

  // Drive one cycle of inputs, then return 1 time unit after the edge.
  task automatic step(input bit v, input int d, input bit m, input bit ordy, input bit clr);
    in_valid  = v;
    in_data   = WIDTH'(d);
    mode      = m;
    out_ready = ordy;
    clear     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic release_result();
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check("reset_in_ready",  32'(in_ready),  32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_sum",   32'(out_sum),   32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back 10,20,30,40 in wrap mode.
    step(1, 10, 0, 0, 0);
    step(1, 20, 0, 0, 0);
    step(1, 30, 0, 0, 0);
    check("b1_not_yet_valid", 32'(out_valid), 32'd0);
    step(1, 40, 0, 0, 0);
    check("b1_valid", 32'(out_valid), 32'd1);
    check("b1_sum",   32'(out_sum),   32'd100);
    check("b1_ovf",   32'(overflow),  32'd0);
    check("b1_cnt",   32'(sample_cnt), 32'd4);
    release_result();
    check("b1_rel_sum",   32'(out_sum),  32'd0);
    check("b1_rel_ready", 32'(in_ready), 32'd1);

    // Wrap: 200+100 -> 44 with overflow; idle gaps between samples.
    step(1, 200, 0, 0, 0);
    idle();
    step(1, 100, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    idle();
    step(1, 0, 0, 0, 0);
    check("b2_sum", 32'(out_sum),  32'd44);
    check("b2_ovf", 32'(overflow), 32'd1);
    release_result();
    check("b2_rel_ovf", 32'(overflow), 32'd0);

    // Saturate stays clamped; then held result ignores in_valid for 5 cycles.
    step(1, 200, 1, 0, 0);
    step(1, 100, 1, 0, 0);
    check("b3_clamp_mid", 32'(out_sum), 32'd255);
    step(1, 5, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    check("b3_sum", 32'(out_sum),  32'd255);
    check("b3_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step(1, 3, 0, 0, 0);
      check("hold_in_ready", 32'(in_ready),   32'd0);
      check("hold_sum",      32'(out_sum),    32'd255);
      check("hold_cnt",      32'(sample_cnt), 32'd4);
    end
    release_result();
    check("hold_rel_sum",   32'(out_sum),  32'd0);
    check("hold_rel_ready", 32'(in_ready), 32'd1);

    // Mode switched per sample: 200(sat) 100(wrap)=44, 250(sat)=255, 1(wrap)=0.
    step(1, 200, 1, 0, 0);
    step(1, 100, 0, 0, 0);
    check("mix_wrap", 32'(out_sum), 32'd44);
    step(1, 250, 1, 0, 0);
    check("mix_sat", 32'(out_sum), 32'd255);
    step(1, 1, 0, 0, 0);
    check("mix_sum", 32'(out_sum),  32'd0);
    check("mix_ovf", 32'(overflow), 32'd1);
    release_result();

    // Clear after 7,9 drops a concurrent sample; out_ready high in ACCUM is inert.
    step(1, 7, 0, 1, 0);
    step(1, 9, 0, 1, 0);
    check("clr_pre_sum", 32'(out_sum), 32'd16);
    step(1, 50, 0, 0, 1);
    check("clr_sum", 32'(out_sum),    32'd0);
    check("clr_cnt", 32'(sample_cnt), 32'd0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 0);
    check("clr_blk_sum", 32'(out_sum),  32'd4);
    check("clr_blk_ovf", 32'(overflow), 32'd0);
    release_result();

    // Clear has priority over release while holding.
    for (int i = 1; i <= 4; i++) step(1, i, 0, 0, 0);
    check("hclr_pre", 32'(out_sum), 32'd10);
    step(1, 9, 0, 1, 1);
    check("hclr_ready", 32'(in_ready), 32'd1);
    check("hclr_sum",   32'(out_sum),  32'd0);

    // Asynchronous reset between edges while holding 100.
    step(1, 10, 0, 0, 0);
    step(1, 20, 0, 0, 0);
    step(1, 30, 0, 0, 0);
    step(1, 40, 0, 0, 0);
    check("ar_pre_sum", 32'(out_sum), 32'd100);
    #2;
    reset = 1'b0;
    #1;
    check("ar_sum",   32'(out_sum),   32'd0);
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_ready", 32'(in_ready),  32'd1);
    check("ar_cnt",   32'(sample_cnt), 32'd0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    // First edge after release accepts.
    step(1, 5, 0, 0, 0);
    check("post_rst_sum", 32'(out_sum),    32'd5);
    check("post_rst_cnt", 32'(sample_cnt), 32'd1);

    // Reset mid-block discards the partial sum.
    step(1, 6, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_sum", 32'(out_sum), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 60, 0, 0, 0);
    check("fresh_sum", 32'(out_sum),  32'd240);
    check("fresh_ovf", 32'(overflow), 32'd0);
    release_result();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_accumulator.md
SEQ_ACCUMULATOR -- requirements
Module: seq_accumulator

Interface
REQ-001 Parameter WIDTH, default 8, is the data and sum width in bits; legal range is 2..32.
REQ-002 Parameter COUNT, default 4, is the number of samples summed per block; legal range is 1..255.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port clear, input, 1 bit: synchronous block abort, active-high.
REQ-006 Port mode, input, 1 bit: 0 selects wrap (modulo 2^WIDTH), 1 selects saturate.
REQ-007 Port in_valid, input, 1 bit: in_data is valid.
REQ-008 Port in_data, input, WIDTH bits: unsigned sample.
REQ-009 Port in_ready, output, 1 bit: the block can accept a sample.
REQ-010 Port out_valid, output, 1 bit: out_sum holds a completed block result.
REQ-011 Port out_sum, output, WIDTH bits: the running or completed unsigned sum.
REQ-012 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 Port overflow, output, 1 bit: at least one addition in the current block exceeded 2^WIDTH-1.
REQ-014 Port sample_cnt, output, 8 bits: number of samples accepted in the current block.

Function
REQ-015 The block SHALL have two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-016 A sample is accepted on any edge where in_valid=1 and in_ready=1; no other edge changes the accumulator.
REQ-017 On accept, next out_sum SHALL be out_sum+in_data computed at WIDTH+1 bits; the carry bit is set when the sum exceeds 2^WIDTH-1.
REQ-018 When mode=0 on the accepting edge, the result SHALL be the low WIDTH bits of the sum.
REQ-019 When mode=1 on the accepting edge and the carry is set, the result SHALL clamp to 2^WIDTH-1.
REQ-020 mode SHALL be sampled per accept; a change in mode mid-block affects only later additions.
REQ-021 A set carry SHALL set overflow, and overflow SHALL remain set (sticky) until the block is released or cleared.
REQ-022 Each accept SHALL increment sample_cnt by 1.
REQ-023 On the accept that brings sample_cnt to COUNT, the state SHALL become HOLD, so out_valid is asserted in the cycle after the last sample is accepted.
REQ-024 In HOLD, out_sum, overflow and sample_cnt SHALL stay stable, and in_valid SHALL be ignored.
REQ-025 In HOLD with out_ready=1, the next edge SHALL set out_sum=0, sample_cnt=0 and overflow=0, and return to ACCUM; no sample is accepted on that edge.
REQ-026 out_ready in ACCUM SHALL have no effect.
REQ-027 clear=1 SHALL have priority over accept and release: the next edge sets out_sum=0, sample_cnt=0, overflow=0 and state ACCUM; a sample presented on that edge is dropped.
REQ-028 With COUNT=1, every accepted sample SHALL produce one result, using a zero starting sum.
REQ-029 The accumulator SHALL always start each block from 0 and carry no value between blocks.

Reset
REQ-030 reset=0 SHALL immediately, without waiting for a clock edge, force state ACCUM, out_sum=0, sample_cnt=0 and overflow=0, giving in_ready=1 and out_valid=0.
REQ-031 Reset during HOLD or mid-block SHALL discard the partial or pending result.
REQ-032 After reset is released, the first accept SHALL be possible on the first rising edge.

Verification (WIDTH=8, COUNT=4)
REQ-033 mode=0, samples 10, 20, 30, 40 back-to-back -> out_valid=1 one cycle after the 4th, out_sum=100, overflow=0, sample_cnt=4.
REQ-034 mode=0, samples 200, 100, 0, 0 -> out_sum=44, overflow=1.
REQ-035 mode=1, samples 200, 100, 5, 0 -> out_sum=255 held (stays clamped), overflow=1.
REQ-036 Result pending with out_ready=0 for 5 cycles and in_valid=1 throughout -> in_ready=0, out_sum stable, no accept; out_ready=1 -> next cycle out_sum=0, in_ready=1.
REQ-037 clear pulsed after 2 samples (7, 9), then samples 1, 1, 1, 1 -> out_sum=4, overflow=0.
REQ-038 reset driven low between clock edges in HOLD (out_sum=100) -> out_sum=0, out_valid=0, in_ready=1 before the next edge.
